// File: rtl/rng_health_monitor_pkg.sv
// Shared types and constants for the rng health tests: FSM states, fail_code
// bit positions and the default cutoffs used across the rng_testing builds.
package rng_health_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FAIL = 2'd2
   } state_t;

   localparam int FC_RCT = 0;
   localparam int FC_APT = 1;

   localparam int DEF_RCT_CUTOFF    = 32;
   localparam int DEF_APT_WINDOW    = 1024;
   localparam int DEF_APT_CUTOFF    = 840;
   localparam int DEF_LED_DIV_WIDTH = 22;

   function automatic bit is_pow2(int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/rng_health_monitor_if.sv
// Sample stream into the health monitor and its status/LED outputs.
interface rng_health_monitor_if;
   import rng_health_monitor_pkg::*;

   // bit_valid qualifies bit_in; there is no ready, every cycle with
   // bit_valid=1 is consumed as exactly one sample and bit_in is ignored otherwise.
   logic       bit_in;
   logic       bit_valid;
   logic       fail;
   logic [1:0] fail_code;
   logic       window_done;
   logic [3:0] gleds;
   logic       rled;
   state_t     state;

   modport master (
      output bit_in, bit_valid,
      input  fail, fail_code, window_done, gleds, rled, state
   );

   modport slave (
      input  bit_in, bit_valid,
      output fail, fail_code, window_done, gleds, rled, state
   );

endinterface

// File: rtl/rng_health_monitor_led_heartbeat.sv
// Free-running divider; toggle flips each time the divider wraps to zero.
module rng_health_monitor_led_heartbeat #(
   parameter int DIV_WIDTH = 22
) (
   input  logic clk,
   input  logic rst,
   output logic toggle
);

   logic [DIV_WIDTH-1:0] div;

   always_ff @(posedge clk) begin
      if (rst) begin
         div    <= '0;
         toggle <= 1'b0;
      end else begin
         div <= div + DIV_WIDTH'(1);
         if (&div) toggle <= ~toggle;
      end
   end

endmodule

// File: rtl/rng_health_monitor.sv
// Continuous repetition-count and adaptive-proportion health tests on an rng
// bit stream, with a sticky failure report and board LED drive.
module rng_health_monitor
   import rng_health_monitor_pkg::*;
#(
   parameter int RCT_CUTOFF    = DEF_RCT_CUTOFF,
   parameter int APT_WINDOW    = DEF_APT_WINDOW,
   parameter int APT_CUTOFF    = DEF_APT_CUTOFF,
   parameter int LED_DIV_WIDTH = DEF_LED_DIV_WIDTH
) (
   input logic                 clk,
   input logic                 rst,
   rng_health_monitor_if.slave bus
);

   localparam int RUN_W = $clog2(RCT_CUTOFF + 1);
   localparam int CNT_W = $clog2(APT_WINDOW + 1);
   localparam int LOG2W = $clog2(APT_WINDOW);

   localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RCT_CUTOFF);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] WIN_FULL = CNT_W'(APT_WINDOW);
   localparam logic [CNT_W-1:0] APT_LIM  = CNT_W'(APT_CUTOFF);

   if (RCT_CUTOFF < 2) begin : g_bad_rct
      $error("rng_health_monitor: RCT_CUTOFF must be >= 2");
   end
   if (APT_WINDOW < 16 || !is_pow2(APT_WINDOW)) begin : g_bad_win
      $error("rng_health_monitor: APT_WINDOW must be a power of two >= 16");
   end
   if (APT_CUTOFF < 1 || APT_CUTOFF > APT_WINDOW) begin : g_bad_apt
      $error("rng_health_monitor: APT_CUTOFF must be in 1..APT_WINDOW");
   end
   if (LED_DIV_WIDTH < 1) begin : g_bad_div
      $error("rng_health_monitor: LED_DIV_WIDTH must be >= 1");
   end

   state_t           state_q, state_d;
   logic             prev_q, prev_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             ref_q, ref_d;
   logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
   logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0] ones_q, ones_d;
   logic [1:0]       code_q, code_d;
   logic             done_q, done_d;
   logic [3:0]       gleds_q, gleds_d;

   logic             rct_hit, apt_hit, new_win;
   logic [RUN_W-1:0] run_step;
   logic [CNT_W-1:0] win_step, ref_step, ones_step;
   logic             ref_bit_step;
   logic             hb_toggle;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         prev_q    <= 1'b0;
         run_q     <= '0;
         ref_q     <= 1'b0;
         ref_cnt_q <= '0;
         win_cnt_q <= '0;
         ones_q    <= '0;
         code_q    <= 2'b00;
         done_q    <= 1'b0;
         gleds_q   <= 4'h0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         run_q     <= run_d;
         ref_q     <= ref_d;
         ref_cnt_q <= ref_cnt_d;
         win_cnt_q <= win_cnt_d;
         ones_q    <= ones_d;
         code_q    <= code_d;
         done_q    <= done_d;
         gleds_q   <= gleds_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      run_d     = run_q;
      ref_d     = ref_q;
      ref_cnt_d = ref_cnt_q;
      win_cnt_d = win_cnt_q;
      ones_d    = ones_q;
      code_d    = code_q;
      done_d    = 1'b0;
      gleds_d   = gleds_q;
      rct_hit   = 1'b0;
      apt_hit   = 1'b0;

      if (bus.bit_in == prev_q) run_step = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;
      else                      run_step = RUN_ONE;

      // A full window counter means this sample opens the next window as its reference.
      new_win      = (win_cnt_q == WIN_FULL);
      win_step     = new_win ? CNT_ONE : win_cnt_q + CNT_ONE;
      ref_bit_step = new_win ? bus.bit_in : ref_q;
      ones_step    = new_win ? CNT_W'(bus.bit_in) : ones_q + CNT_W'(bus.bit_in);
      if (new_win)                    ref_step = CNT_ONE;
      else if (bus.bit_in == ref_q)   ref_step = ref_cnt_q + CNT_ONE;
      else                            ref_step = ref_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.bit_valid) begin
               prev_d    = bus.bit_in;
               run_d     = RUN_ONE;
               ref_d     = bus.bit_in;
               ref_cnt_d = CNT_ONE;
               win_cnt_d = CNT_ONE;
               ones_d    = CNT_W'(bus.bit_in);
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.bit_valid) begin
               prev_d    = bus.bit_in;
               run_d     = run_step;
               ref_d     = ref_bit_step;
               ref_cnt_d = ref_step;
               win_cnt_d = win_step;
               ones_d    = ones_step;
               rct_hit   = (run_step == RUN_MAX);
               apt_hit   = (ref_step == APT_LIM);
               if (rct_hit || apt_hit) begin
                  state_d        = ST_FAIL;
                  code_d[FC_RCT] = rct_hit;
                  code_d[FC_APT] = apt_hit;
               end else if (win_step == WIN_FULL) begin
                  done_d  = 1'b1;
                  gleds_d = (ones_step == WIN_FULL) ? 4'hF : ones_step[LOG2W-1 -: 4];
               end
            end
         end
         ST_FAIL: begin
         end
         default: state_d = ST_IDLE;
      endcase
   end

   rng_health_monitor_led_heartbeat #(
      .DIV_WIDTH(LED_DIV_WIDTH)
   ) u_heartbeat (
      .clk   (clk),
      .rst   (rst),
      .toggle(hb_toggle)
   );

   assign bus.fail        = |code_q;
   assign bus.fail_code   = code_q;
   assign bus.window_done = done_q;
   assign bus.gleds       = gleds_q;
   assign bus.rled        = (|code_q) ? 1'b1 : hb_toggle;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_rng_health_monitor.sv
// Randomized scoreboard bench for rng_health_monitor against a window-list reference model.
module tb_rng_health_monitor;
   import rng_health_monitor_pkg::*;

   localparam int RCT = 8;
   localparam int W   = 16;
   localparam int APC = 13;
   localparam int DIVW = 4;

   logic clk;
   logic rst;
   rng_health_monitor_if bus();

   rng_health_monitor #(
      .RCT_CUTOFF(RCT), .APT_WINDOW(W), .APT_CUTOFF(APC), .LED_DIV_WIDTH(DIVW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   // event = {kind(01 window, 10 fail), fail_code, gleds}
   logic [7:0] exp_q[$];

   bit         m_started, m_failed, m_prev;
   int         m_run;
   bit         m_win[$];
   logic [1:0] m_code;
   logic [3:0] m_gleds;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking helpers ----------------
   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pop_check(string name, logic [7:0] act);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: got unexpected event %0h expected none", name, act);
      end else begin
         e = exp_q.pop_front();
         check(name, act, e);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_reset();
      m_started = 0;
      m_failed  = 0;
      m_prev    = 0;
      m_run     = 0;
      m_win.delete();
      m_code    = 2'b00;
      m_gleds   = 4'h0;
   endtask

   task automatic model_sample(bit b);
      int ref_count, ones;
      bit rct, apt;
      if (m_failed) return;
      if (m_win.size() == W) m_win.delete();
      m_win.push_back(b);
      m_run     = (m_started && b == m_prev) ? m_run + 1 : 1;
      m_prev    = b;
      m_started = 1;
      ref_count = 0;
      ones      = 0;
      foreach (m_win[i]) begin
         if (m_win[i] == m_win[0]) ref_count++;
         if (m_win[i]) ones++;
      end
      rct = (m_run >= RCT);
      apt = (ref_count >= APC);
      if (rct || apt) begin
         m_failed = 1;
         m_code   = {apt, rct};
         exp_q.push_back({2'b10, m_code, m_gleds});
      end else if (m_win.size() == W) begin
         m_gleds = (ones == W) ? 4'hF : 4'((ones * 16) / W);
         exp_q.push_back({2'b01, 2'b00, m_gleds});
      end
   endtask

   function automatic state_t model_state();
      if (!m_started) return ST_IDLE;
      if (m_failed)   return ST_FAIL;
      return ST_RUN;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send(bit b);
      @(negedge clk);
      bus.bit_in    = b;
      bus.bit_valid = 1'b1;
      @(posedge clk);
      model_sample(b);
   endtask

   task automatic idle(int n, bit hold_bit);
      repeat (n) begin
         @(negedge clk);
         bus.bit_valid = 1'b0;
         if (!hold_bit) bus.bit_in = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic do_reset(int n);
      @(negedge clk);
      rst           = 1'b1;
      bus.bit_valid = 1'b0;
      repeat (n) @(posedge clk);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_reset_state();
      check("rst_fail", bus.fail, 0);
      check("rst_fail_code", bus.fail_code, 0);
      check("rst_gleds", bus.gleds, 0);
      check("rst_rled", bus.rled, 0);
      check("rst_window_done", bus.window_done, 0);
      check("rst_state", bus.state, ST_IDLE);
   endtask

   task automatic drain(string name);
      idle(3, 0);
      check({name, "_pending"}, exp_q.size(), 0);
      check({name, "_fail"}, bus.fail, m_failed);
      check({name, "_code"}, bus.fail_code, m_code);
      check({name, "_state"}, bus.state, model_state());
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic prev_fail;
      prev_fail = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_fail = 1'b0;
         end else begin
            if (bus.window_done) pop_check("window_event", {2'b01, bus.fail_code, bus.gleds});
            if (bus.fail && !prev_fail) pop_check("fail_event", {2'b10, bus.fail_code, bus.gleds});
            if (bus.fail) check("rled_steady", bus.rled, 1);
            prev_fail = bus.fail;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int toggles, last_t;
      logic last_rled;
      int probs[4] = '{50, 90, 97, 20};

      rst           = 1'b1;
      bus.bit_in    = 1'b0;
      bus.bit_valid = 1'b0;
      model_reset();
      do_reset(3);
      check_reset_state();

      // alternating stream with random idle gaps: four clean windows, gleds=1000
      for (int i = 0; i < 64; i++) begin
         if ($urandom_range(0, 2) == 0) idle(1, 0);
         send(1'(i % 2));
      end
      drain("alt64");
      check("alt64_gleds", bus.gleds, 4'b1000);

      // 0 then eight 1s: repetition failure, later samples ignored
      send(1'b0);
      for (int i = 0; i < 8; i++) send(1'b1);
      for (int i = 0; i < 20; i++) send(1'($urandom_range(0, 1)));
      drain("rct");
      check("rct_gleds_hold", bus.gleds, 4'b1000);

      // 13th reference zero lands on window-end sample: fail wins
      do_reset(3);
      check_reset_state();
      for (int i = 0; i < 16; i++) send((i == 4 || i == 9 || i == 14) ? 1'b1 : 1'b0);
      drain("apt_end");
      check("apt_end_gleds", bus.gleds, 0);

      // seven 1s with long invalid gaps, bit_in held high
      do_reset(3);
      for (int i = 0; i < 7; i++) begin
         send(1'b1);
         idle(100, 1);
      end
      drain("gap7");

      // fail, then a one-cycle reset clears everything; heartbeat then stream passes
      for (int i = 0; i < 2; i++) send(1'b1);
      drain("gap_fail");
      do_reset(1);
      check_reset_state();
      toggles   = 0;
      last_t    = 0;
      last_rled = bus.rled;
      for (int t = 1; t <= 60; t++) begin
         @(negedge clk);
         if (bus.rled !== last_rled) begin
            toggles++;
            if (toggles == 1) check("hb_first", t, 16);
            else              check("hb_period", t - last_t, 16);
            last_t    = t;
            last_rled = bus.rled;
         end
      end
      check("hb_toggles", toggles, 3);
      for (int i = 0; i < 32; i++) send(1'(i % 2));
      drain("post_rst");

      // biased random streams; reset after failures
      do_reset(2);
      foreach (probs[p]) begin
         for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1, 0);
            send(($urandom_range(0, 99) < probs[p]) ? 1'b1 : 1'b0);
            if (m_failed && $urandom_range(0, 9) == 0) begin
               drain("rand_fail");
               do_reset(1);
            end
         end
         drain("rand_block");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
